cv32e40s_obi_resp_tracker: RTL

Parametrised OBI outstanding-transaction tracker for the instruction and data interfaces. It records per-transaction attributes at address-phase acceptance in a circular FIFO and presents them in the matching response phase: PMA/user attribute bits, sticky gnt parity error, and the store flag. It also drives the rchk enables and detects protocol violations: unexpected rvalid, grant overflow, and optional response timeout. It sits between the OBI interface and the rchk checker in the load-store unit and the instruction fetch path.

---
 rtl/cv32e40s_obi_resp_tracker.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/cv32e40s_obi_resp_tracker.sv
// Records OBI transaction attributes at grant and presents them at the matching response; flags protocol errors.
// Response timeout watchdog is built only when CV32E40S_OBI_TRACKER_TIMEOUT_EN is defined.
module cv32e40s_obi_resp_tracker #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ATTR_W          = 1,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   gntpar_err_i,
  input  logic [ATTR_W-1:0]                      trans_attr_i,
  input  logic                                   trans_we_i,
  input  logic                                   integrity_en_i,
  input  logic                                   obi_req_i,
  input  logic                                   obi_gnt_i,
  input  logic                                   obi_rvalid_i,
  output logic [ATTR_W-1:0]                      resp_attr_o,
  output logic                                   resp_gnterr_o,
  output logic                                   resp_store_o,
  output logic [1:0]                             rchk_en_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   full_o,
  output logic                                   empty_o,
  output logic                                   err_unexpected_o,
  output logic                                   err_overflow_o,
  output logic                                   err_timeout_o,
  output logic                                   protocol_err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef struct packed {
    logic [ATTR_W-1:0] attr;
    logic              gnterr;
    logic              store;
  } entry_t;

  entry_t             fifo_q [MAX_OUTSTANDING];
  entry_t             wr_entry;
  entry_t             head;
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               gntpar_q, gntpar_d;
  logic               empty, full, push, pop, addr_hs;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign addr_hs = obi_req_i & obi_gnt_i;
  assign pop     = obi_rvalid_i & ~empty;
  assign push    = addr_hs & (~full | pop);

  // A parity error seen on any cycle of a stalled address phase marks the eventual entry.
  assign wr_entry = '{attr: trans_attr_i, gnterr: gntpar_err_i | gntpar_q, store: trans_we_i};

  always_comb begin
    wptr_d   = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d   = pop  ? ptr_inc(rptr_q) : rptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    gntpar_d = gntpar_q;
    if (obi_req_i && !obi_gnt_i) begin
      gntpar_d = gntpar_q | gntpar_err_i;
    end else if (addr_hs) begin
      gntpar_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      gntpar_q <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      gntpar_q <= gntpar_d;
      if (push) begin
        fifo_q[wptr_q] <= wr_entry;
      end
    end
  end

  assign head          = fifo_q[rptr_q];
  assign resp_attr_o   = empty ? '0 : head.attr;
  assign resp_gnterr_o = ~empty & head.gnterr;
  assign resp_store_o  = ~empty & head.store;

  // Stores carry no read data, so only the response-phase check bit applies to them.
  assign rchk_en_o[1]  = obi_rvalid_i & integrity_en_i & ~empty;
  assign rchk_en_o[0]  = obi_rvalid_i & integrity_en_i & ~empty & ~resp_store_o;

  assign outstanding_o = count_q;
  assign full_o        = full;
  assign empty_o       = empty;

  // A response in the grant cycle of an empty tracker is unexpected; the grant is still recorded.
  assign err_unexpected_o = obi_rvalid_i & empty;
  assign err_overflow_o   = addr_hs & full & ~pop;

`ifdef CV32E40S_OBI_TRACKER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit;

  assign tmo_hit = ~empty & ~pop & (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = tmo_q + TMO_W'(1);
    if (empty || pop || tmo_hit) begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign err_timeout_o = tmo_hit;
`else
  assign err_timeout_o = 1'b0;
`endif

  assign protocol_err_o = err_unexpected_o | err_overflow_o | err_timeout_o;

endmodule
